// File: rtl/sd_fifo_sched_if.sv
// SD sector scheduler bus: FIFO flags/strobes and shared SD port.
// master = scheduler side, slave = FIFO/SD side.
interface sd_fifo_sched_if;
  logic        sd_init_done;
  logic        play_en;
  logic        prog_full_save;
  logic        empty_save;
  logic        prog_empty_read;
  logic        full_read;
  logic        fifo_rd_req_save;
  logic        fifo_wr_req_read;
  logic        sd_wr_start_en;
  logic [31:0] sd_wr_sec_addr;
  logic        sd_wr_busy;
  logic        sd_wr_req;
  logic        sd_rd_start_en;
  logic [31:0] sd_rd_sec_addr;
  logic        sd_rd_busy;
  logic        sd_rd_val_en;
  logic [10:0] sec_avail;
  logic        err_flag;

  modport master (
    input  sd_init_done, play_en, prog_full_save, empty_save,
    input  prog_empty_read, full_read,
    input  sd_wr_busy, sd_wr_req, sd_rd_busy, sd_rd_val_en,
    output fifo_rd_req_save, fifo_wr_req_read,
    output sd_wr_start_en, sd_wr_sec_addr,
    output sd_rd_start_en, sd_rd_sec_addr,
    output sec_avail, err_flag
  );

  modport slave (
    output sd_init_done, play_en, prog_full_save, empty_save,
    output prog_empty_read, full_read,
    output sd_wr_busy, sd_wr_req, sd_rd_busy, sd_rd_val_en,
    input  fifo_rd_req_save, fifo_wr_req_read,
    input  sd_wr_start_en, sd_wr_sec_addr,
    input  sd_rd_start_en, sd_rd_sec_addr,
    input  sec_avail, err_flag
  );
endinterface

// File: rtl/sd_fifo_sched.sv
// SD card sector scheduler: moves save-FIFO sectors into a ring on
// the card and plays them back into the read FIFO, one at a time.
module sd_fifo_sched #(
  parameter int          SEC_WORDS = 256,
  parameter logic [31:0] WR_BASE   = 32'd16384,
  parameter int          RING_SECS = 1024
) (
  input  logic            clk_50m,
  input  logic            rst_n,
  sd_fifo_sched_if.master bus
);

  localparam int          CW        = $clog2(SEC_WORDS + 1) + 1;
  localparam logic [31:0] WR_LAST   = WR_BASE + 32'(RING_SECS) - 32'd1;
  localparam logic [10:0] RING_FULL = 11'(RING_SECS);
  localparam logic [CW-1:0] SEC_CNT = CW'(SEC_WORDS);

  typedef enum logic [2:0] {
    IDLE, WR_START, WR_WAIT, WR_XFER,
    RD_START, RD_WAIT, RD_XFER
  } state_t;

  state_t        state, state_nxt;
  logic          last_rd;
  logic [31:0]   wr_ptr, rd_ptr;
  logic [10:0]   avail;
  logic [CW-1:0] cnt, cnt_add;
  logic          err;
  logic          wr_pend, rd_pend;
  logic          st_wr, st_rd, pop, push;
  logic          word_inc, wr_done, rd_done;

  function automatic logic [31:0] nxt_ptr(input logic [31:0] p);
    return (p == WR_LAST) ? WR_BASE : p + 32'd1;
  endfunction

  assign wr_pend = bus.sd_init_done & bus.prog_full_save;
  assign rd_pend = bus.sd_init_done & bus.play_en &
                   bus.prog_empty_read & (avail != 11'd0);

  assign cnt_add = (word_inc && cnt != '1) ? cnt + CW'(1) : cnt;

  assign bus.fifo_rd_req_save = pop;
  assign bus.fifo_wr_req_read = push;
  assign bus.sd_wr_start_en   = st_wr;
  assign bus.sd_rd_start_en   = st_rd;
  assign bus.sd_wr_sec_addr   = wr_ptr;
  assign bus.sd_rd_sec_addr   = rd_ptr;
  assign bus.sec_avail        = avail;
  assign bus.err_flag         = err;

  // State register
  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state, arbitration and transfer strobes
  always_comb begin
    state_nxt = state;
    st_wr     = 1'b0;
    st_rd     = 1'b0;
    pop       = 1'b0;
    push      = 1'b0;
    word_inc  = 1'b0;
    wr_done   = 1'b0;
    rd_done   = 1'b0;
    unique case (state)
      IDLE: begin
        if (wr_pend && (!rd_pend || last_rd)) state_nxt = WR_START;
        else if (rd_pend)                     state_nxt = RD_START;
      end
      WR_START: begin
        st_wr     = 1'b1;
        state_nxt = WR_WAIT;
      end
      WR_WAIT: if (bus.sd_wr_busy) state_nxt = WR_XFER;
      WR_XFER: begin
        pop      = bus.sd_wr_req;
        word_inc = bus.sd_wr_req;
        if (!bus.sd_wr_busy) begin
          wr_done   = 1'b1;
          state_nxt = IDLE;
        end
      end
      RD_START: begin
        st_rd     = 1'b1;
        state_nxt = RD_WAIT;
      end
      RD_WAIT: if (bus.sd_rd_busy) state_nxt = RD_XFER;
      RD_XFER: begin
        push     = bus.sd_rd_val_en & ~bus.full_read;
        word_inc = bus.sd_rd_val_en;
        if (!bus.sd_rd_busy) begin
          rd_done   = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Grant history, word count, ring pointers and sticky error
  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      last_rd <= 1'b1;
      cnt     <= '0;
      wr_ptr  <= WR_BASE;
      rd_ptr  <= WR_BASE;
      avail   <= '0;
      err     <= 1'b0;
    end else begin
      if (state == IDLE && state_nxt == WR_START) last_rd <= 1'b0;
      if (state == IDLE && state_nxt == RD_START) last_rd <= 1'b1;
      if (st_wr || st_rd) cnt <= '0;
      else                cnt <= cnt_add;
      if (state == WR_XFER && bus.sd_wr_req && bus.empty_save)
        err <= 1'b1;
      if (state == RD_XFER && bus.sd_rd_val_en && bus.full_read)
        err <= 1'b1;
      if ((wr_done || rd_done) && cnt_add != SEC_CNT)
        err <= 1'b1;
      if (wr_done) begin
        wr_ptr <= nxt_ptr(wr_ptr);
        if (avail == RING_FULL) rd_ptr <= nxt_ptr(rd_ptr);
        else                    avail  <= avail + 11'd1;
      end
      if (rd_done) begin
        rd_ptr <= nxt_ptr(rd_ptr);
        avail  <= avail - 11'd1;
      end
    end
  end

endmodule

// File: tb/tb_sd_fifo_sched.sv
// Directed bench for sd_fifo_sched: sector table, arbitration,
// ring wrap/overwrite and mid-transfer reset sequences.
module tb_sd_fifo_sched;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #10 clk = ~clk;

  sd_fifo_sched_if bus ();

  sd_fifo_sched dut (
    .clk_50m (clk),
    .rst_n   (rst_n),
    .bus     (bus)
  );

  int checks = 0;
  int errors = 0;
  int pops   = 0;
  int pushes = 0;
  int wr_starts = 0;

  always @(negedge clk) begin
    if (bus.fifo_rd_req_save) pops++;
    if (bus.fifo_wr_req_read) pushes++;
    if (bus.sd_wr_start_en)   wr_starts++;
  end

  typedef struct {
    bit          rst;
    bit          wr;
    int          nw;
    bit          flag;
    logic [31:0] eaddr;
    int          ewords;
    logic [10:0] eavail;
    bit          eerr;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic clr_inputs();
    bus.sd_init_done    = 1'b0;
    bus.play_en         = 1'b0;
    bus.prog_full_save  = 1'b0;
    bus.empty_save      = 1'b0;
    bus.prog_empty_read = 1'b0;
    bus.full_read       = 1'b0;
    bus.sd_wr_busy      = 1'b0;
    bus.sd_wr_req       = 1'b0;
    bus.sd_rd_busy      = 1'b0;
    bus.sd_rd_val_en    = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clr_inputs();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    bus.sd_init_done = 1'b1;
    @(negedge clk);
  endtask

  // Wait for a start pulse, then act as the SD engine for nw words.
  task automatic svc(input int nw, input bit keep, output bit ok,
                     output bit is_wr, output logic [31:0] addr,
                     output int words);
    int p0, q0;
    ok = 1'b0; is_wr = 1'b0; addr = '0; words = 0;
    for (int i = 0; i < 64 && !ok; i++) begin
      @(negedge clk);
      if (bus.sd_wr_start_en) begin
        ok = 1'b1; is_wr = 1'b1; addr = bus.sd_wr_sec_addr;
      end else if (bus.sd_rd_start_en) begin
        ok = 1'b1; addr = bus.sd_rd_sec_addr;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL start_timeout: got none expected start pulse");
      return;
    end
    if (!keep) begin
      bus.prog_full_save  = 1'b0;
      bus.prog_empty_read = 1'b0;
    end
    @(posedge clk); #1;
    p0 = pops; q0 = pushes;
    if (is_wr) bus.sd_wr_busy = 1'b1;
    else       bus.sd_rd_busy = 1'b1;
    @(posedge clk); #1;
    for (int k = 0; k < nw; k++) begin
      if (is_wr) bus.sd_wr_req = 1'b1;
      else       bus.sd_rd_val_en = 1'b1;
      @(posedge clk); #1;
    end
    bus.sd_wr_req    = 1'b0;
    bus.sd_rd_val_en = 1'b0;
    bus.sd_wr_busy   = 1'b0;
    bus.sd_rd_busy   = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    words = is_wr ? pops - p0 : pushes - q0;
  endtask

  initial begin
    bit          ok, is_wr;
    logic [31:0] addr;
    int          words, bad, s0;
    logic [31:0] arb_addr [4];
    bit          arb_wr   [4];

    vecs[0] = '{1, 1, 256, 0, 32'd16384, 256, 11'd1, 0};
    vecs[1] = '{0, 1, 256, 0, 32'd16385, 256, 11'd2, 0};
    vecs[2] = '{0, 0, 256, 0, 32'd16384, 256, 11'd1, 0};
    vecs[3] = '{0, 0, 256, 0, 32'd16385, 256, 11'd0, 0};
    vecs[4] = '{0, 1, 200, 0, 32'd16386, 200, 11'd1, 1};
    vecs[5] = '{1, 1, 256, 0, 32'd16384, 256, 11'd1, 0};
    vecs[6] = '{0, 0, 256, 1, 32'd16384, 0,   11'd0, 1};
    vecs[7] = '{1, 1, 256, 1, 32'd16384, 256, 11'd1, 1};

    arb_wr[0] = 1; arb_addr[0] = 32'd16384;
    arb_wr[1] = 0; arb_addr[1] = 32'd16384;
    arb_wr[2] = 1; arb_addr[2] = 32'd16385;
    arb_wr[3] = 0; arb_addr[3] = 32'd16385;

    clr_inputs();
    do_reset();

    // Reset state; stray engine strobes in IDLE are ignored
    bus.sd_init_done = 1'b0;
    bus.sd_wr_req    = 1'b1;
    bus.sd_rd_val_en = 1'b1;
    @(negedge clk);
    chk("rst_wr_addr", bus.sd_wr_sec_addr, 32'd16384);
    chk("rst_rd_addr", bus.sd_rd_sec_addr, 32'd16384);
    chk("rst_avail", 32'(bus.sec_avail), 0);
    chk("rst_err", 32'(bus.err_flag), 0);
    chk("idle_pop", 32'(bus.fifo_rd_req_save), 0);
    chk("idle_push", 32'(bus.fifo_wr_req_read), 0);
    bus.sd_wr_req    = 1'b0;
    bus.sd_rd_val_en = 1'b0;

    // No start while card not ready
    s0 = wr_starts;
    bus.prog_full_save = 1'b1;
    repeat (10) @(negedge clk);
    chk("init_gate", 32'(wr_starts - s0), 0);
    bus.prog_full_save = 1'b0;

    // Table of single-sector transactions
    for (int v = 0; v < 8; v++) begin
      if (vecs[v].rst) do_reset();
      if (vecs[v].wr) begin
        bus.prog_full_save = 1'b1;
        bus.empty_save     = vecs[v].flag;
      end else begin
        bus.play_en         = 1'b1;
        bus.prog_empty_read = 1'b1;
        bus.full_read       = vecs[v].flag;
      end
      svc(vecs[v].nw, 1'b0, ok, is_wr, addr, words);
      bus.empty_save = 1'b0;
      bus.full_read  = 1'b0;
      bus.play_en    = 1'b0;
      chk($sformatf("v%0d_dir", v), 32'(is_wr), 32'(vecs[v].wr));
      chk($sformatf("v%0d_addr", v), addr, vecs[v].eaddr);
      chk($sformatf("v%0d_words", v), words, vecs[v].ewords);
      chk($sformatf("v%0d_avail", v), 32'(bus.sec_avail),
          32'(vecs[v].eavail));
      chk($sformatf("v%0d_err", v), 32'(bus.err_flag),
          32'(vecs[v].eerr));
    end

    // Both pending: grants alternate, reads trail writes
    do_reset();
    bus.prog_full_save  = 1'b1;
    bus.play_en         = 1'b1;
    bus.prog_empty_read = 1'b1;
    for (int g = 0; g < 4; g++) begin
      svc(256, 1'b1, ok, is_wr, addr, words);
      chk($sformatf("arb%0d_dir", g), 32'(is_wr), 32'(arb_wr[g]));
      chk($sformatf("arb%0d_addr", g), addr, arb_addr[g]);
    end
    bus.prog_full_save  = 1'b0;
    bus.prog_empty_read = 1'b0;
    bus.play_en         = 1'b0;
    chk("arb_err", 32'(bus.err_flag), 0);

    // Fill the ring, then overwrite the oldest sector
    do_reset();
    bus.prog_full_save = 1'b1;
    bad = 0;
    for (int i = 0; i < 1024; i++) begin
      svc(0, 1'b1, ok, is_wr, addr, words);
      if (!ok || !is_wr || addr != 32'd16384 + 32'(i)) bad++;
    end
    chk("wrap_seq", bad, 0);
    chk("full_avail", 32'(bus.sec_avail), 1024);
    chk("wrap_wr_addr", bus.sd_wr_sec_addr, 32'd16384);
    chk("full_rd_addr", bus.sd_rd_sec_addr, 32'd16384);
    svc(0, 1'b0, ok, is_wr, addr, words);
    chk("ovw_addr", addr, 32'd16384);
    chk("ovw_avail", 32'(bus.sec_avail), 1024);
    chk("ovw_rd_addr", bus.sd_rd_sec_addr, 32'd16385);
    chk("ovw_wr_addr", bus.sd_wr_sec_addr, 32'd16385);

    // Reset in the middle of a write sector
    do_reset();
    bus.prog_full_save = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 64 && !ok; i++) begin
      @(negedge clk);
      if (bus.sd_wr_start_en) ok = 1'b1;
    end
    chk("mid_start", 32'(ok), 1);
    bus.prog_full_save = 1'b0;
    @(posedge clk); #1 bus.sd_wr_busy = 1'b1;
    @(posedge clk); #1;
    for (int k = 0; k < 100; k++) begin
      bus.sd_wr_req = 1'b1;
      @(posedge clk); #1;
    end
    chk("mid_pop", 32'(bus.fifo_rd_req_save), 1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_pop", 32'(bus.fifo_rd_req_save), 0);
    chk("mid_rst_start", 32'(bus.sd_wr_start_en), 0);
    chk("mid_rst_addr", bus.sd_wr_sec_addr, 32'd16384);
    chk("mid_rst_avail", 32'(bus.sec_avail), 0);
    chk("mid_rst_err", 32'(bus.err_flag), 0);
    bus.sd_wr_req  = 1'b0;
    bus.sd_wr_busy = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("post_rst_addr", bus.sd_wr_sec_addr, 32'd16384);
    chk("post_rst_avail", 32'(bus.sec_avail), 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
